// File: rtl/mem_bridge.sv
// mem_bridge: bridges a level-held core load/store request (MemRd/MemWr,
// held until MemDone) onto a valid/ready bus request channel with a
// separate read-response channel.
//
// Handshake rules:
//   - The bus request (m_valid, m_we, m_addr, m_wdata) is offered from the
//     cycle after acceptance.
//   - It stays stable until m_valid & m_ready is seen on a rising edge.
//   - A read then waits for m_rvalid; m_rvalid is ignored in every other state.
//   - The core sees Busy from the cycle after acceptance through the DONE
//     cycle, and a one-cycle MemDone pulse with MemErr qualifying it.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to build a stall counter.
// It aborts a transaction that sits in REQ/RESP for TIMEOUT_CYCLES cycles.
// Without the macro, no counter exists and the bridge waits indefinitely.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        MemDone,
  output logic        MemErr,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  logic   timeout;

  // The counter width must be able to hold TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be in 1..65536");
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 256) ? 16 : 8;

  logic [CW-1:0] to_cnt;

  // The abort fires on the edge where the count of REQ/RESP cycles reaches TIMEOUT_CYCLES.
  assign timeout = (int'(to_cnt) >= (TIMEOUT_CYCLES - 1));

  // Stall counter: held at zero while idle, counts REQ/RESP cycles, saturates at the abort point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if ((state == REQ || state == RESP) && !timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Transaction FSM with all core- and bus-facing outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ReadData <= '0;
      Busy     <= 1'b0;
      MemDone  <= 1'b0;
      MemErr   <= 1'b0;
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      MemDone <= 1'b0;
      MemErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (MemRd || MemWr) begin
            // A write wins when both request lines are high.
            m_addr  <= Adr;
            m_wdata <= WriteData;
            m_we    <= MemWr;
            Busy    <= 1'b1;
            if (Adr[1:0] != 2'b00) begin
              // A misaligned access never reaches the bus.
              state   <= DONE;
              MemDone <= 1'b1;
              MemErr  <= 1'b1;
            end else begin
              state   <= REQ;
              m_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (timeout) begin
            m_valid <= 1'b0;
            state   <= DONE;
            MemDone <= 1'b1;
            MemErr  <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            if (m_we) begin
              state   <= DONE;
              MemDone <= 1'b1;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (timeout) begin
            state   <= DONE;
            MemDone <= 1'b1;
            MemErr  <= 1'b1;
          end else if (m_rvalid) begin
            ReadData <= m_rdata;
            state    <= DONE;
            MemDone  <= 1'b1;
          end
        end
        DONE: begin
          // Request lines are ignored here; the core drops them during MemDone.
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycle count after which a stalled bus transaction is aborted (used only when the timeout feature is compiled in).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Adr  in  32  core byte address, sampled only on request acceptance.
REQ-005 WriteData  in  32  core store data, sampled only on request acceptance.
REQ-006 MemRd  in  1  core read request, level, held until MemDone.
REQ-007 MemWr  in  1  core write request, level, held until MemDone.
REQ-008 ReadData  out  32  registered read data, held until the next successful read completes.
REQ-009 Busy  out  1  high from the cycle after acceptance through the DONE cycle; the controller stalls on it.
REQ-010 MemDone  out  1  one-cycle completion pulse.
REQ-011 MemErr  out  1  error status, valid only while MemDone=1.
REQ-012 m_valid  out  1, m_we  out  1, m_addr  out  32, m_wdata  out  32  bus request channel, all registered.
REQ-013 m_ready  in  1  bus accepts the request when m_valid&m_ready.
REQ-014 m_rvalid  in  1, m_rdata  in  32  bus read-response channel.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, RESP, DONE.
REQ-016 IDLE with MemRd|MemWr=1: capture Adr, WriteData, and op (write if MemWr=1, so MemWr wins when both are high) -> REQ; otherwise remain in IDLE.
REQ-017 Acceptance with Adr[1:0]!=0: no bus request; -> DONE with MemErr=1.
REQ-018 REQ: m_valid=1, m_addr/m_wdata/m_we from captured values, stable until handshake; on m_ready=1, a write -> DONE and a read -> RESP.
REQ-019 m_rvalid SHALL be ignored in every state except RESP.
REQ-020 RESP: m_valid=0; on m_rvalid=1, ReadData<=m_rdata -> DONE.
REQ-021 DONE: MemDone=1 for exactly one cycle; MemRd/MemWr ignored; -> IDLE.
REQ-022 The core SHALL drop its request in the MemDone cycle; a request still high in the following IDLE starts a new transaction.
REQ-023 Minimum latency from acceptance edge to MemDone: 2 cycles for a write, 3 cycles for a read.
REQ-024 ReadData SHALL be unchanged by writes, errors and timeouts.

Reset
REQ-025 When reset=0 (asynchronously): state=IDLE, ReadData=0, Busy=0, MemDone=0, MemErr=0, m_valid=0, m_we=0, m_addr=0, m_wdata=0, timeout counter=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no MemDone pulse; after reset release, the bridge SHALL accept only new requests.

Configuration
REQ-027 With macro MEM_BRIDGE_TIMEOUT_EN defined:
- An 8..16-bit counter clears on acceptance and increments each cycle in REQ/RESP.
- On reaching TIMEOUT_CYCLES: m_valid=0, go to DONE with MemErr=1.
REQ-028 Without MEM_BRIDGE_TIMEOUT_EN:
- No counter is built.
- REQ/RESP wait indefinitely.
- MemErr is set only by misalignment.

Verification
REQ-029 Write: MemWr=1, Adr=0x100, WriteData=0xDEADBEEF, m_ready=1 -> m_valid one cycle with m_addr=0x100, m_we=1; MemDone 2 cycles after acceptance; MemErr=0.
REQ-030 Read:
- Stimulus: MemRd=1, Adr=0x200, m_ready stalled 3 cycles, then m_rvalid=1 with m_rdata=0x12345678.
- Response: m_addr held stable through the stall; ReadData=0x12345678 in the MemDone cycle and afterwards.
REQ-031 Misaligned: MemRd=1, Adr=0x202 -> no m_valid; MemDone with MemErr=1; ReadData unchanged.
REQ-032 Priority and protocol:
- MemRd=MemWr=1 -> write performed (m_we=1).
- A stray m_rvalid in IDLE or REQ -> no effect.
- Request held one cycle after MemDone -> a second transaction starts.
REQ-033 Reset/timeout:
- reset=0 while in RESP -> all outputs 0 immediately, no MemDone.
- With MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, m_ready=0 forever -> MemDone with MemErr=1, 5 cycles after acceptance.
